// File: rtl/aq_cp0_hpcp_acc_ctrl_if.sv
// Signal bundle between the IU CSR pipe, the HPCP unit and the CP0 HPCP access sequencer.
// The slave view belongs to the sequencer; the master view belongs to its IU/HPCP neighbours.
interface aq_cp0_hpcp_acc_ctrl_if;
    logic        iui_hpcp_req_vld;
    logic        iui_hpcp_wen;
    logic [11:0] iui_hpcp_idx;
    logic [63:0] iui_hpcp_wdata;
    logic        iui_flush;
    logic        regs_smode;
    logic        regs_umode;
    logic [31:0] mcnten_value;
    logic [31:0] scnten_value;
    logic [31:0] mcntwen_value;
    logic        hpcp_cp0_ack;
    logic [63:0] hpcp_cp0_data;
    logic        cp0_hpcp_req;
    logic        cp0_hpcp_wen;
    logic [11:0] cp0_hpcp_idx;
    logic [63:0] cp0_hpcp_wdata;
    logic        hpcp_iui_done;
    logic        hpcp_iui_expt;
    logic [63:0] hpcp_iui_rdata;
    logic        hpcp_iui_busy;

    modport slave (
        input  iui_hpcp_req_vld, iui_hpcp_wen, iui_hpcp_idx, iui_hpcp_wdata, iui_flush,
        input  regs_smode, regs_umode, mcnten_value, scnten_value, mcntwen_value,
        input  hpcp_cp0_ack, hpcp_cp0_data,
        output cp0_hpcp_req, cp0_hpcp_wen, cp0_hpcp_idx, cp0_hpcp_wdata,
        output hpcp_iui_done, hpcp_iui_expt, hpcp_iui_rdata, hpcp_iui_busy
    );

    modport master (
        output iui_hpcp_req_vld, iui_hpcp_wen, iui_hpcp_idx, iui_hpcp_wdata, iui_flush,
        output regs_smode, regs_umode, mcnten_value, scnten_value, mcntwen_value,
        output hpcp_cp0_ack, hpcp_cp0_data,
        input  cp0_hpcp_req, cp0_hpcp_wen, cp0_hpcp_idx, cp0_hpcp_wdata,
        input  hpcp_iui_done, hpcp_iui_expt, hpcp_iui_rdata, hpcp_iui_busy
    );
endinterface

// File: rtl/aq_cp0_hpcp_acc_ctrl.sv
// CP0 sequencer for IU CSR accesses to HPCP: privilege check, req/ack handshake with timeout,
// flush draining, and a single-cycle done/expt/rdata response back to the IU.
module aq_cp0_hpcp_acc_ctrl #(
    parameter int TIMEOUT = 16
) (
    input logic                    regs_clk,
    input logic                    cpurst_b,
    aq_cp0_hpcp_acc_ctrl_if.slave  bus
);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_DRAIN} state_t;

    state_t        state, nxt;
    logic          req_q, req_nxt;
    logic          wen_q;
    logic [11:0]   idx_q;
    logic [63:0]   wdata_q;
    logic          expt_q, expt_nxt;
    logic [63:0]   rdata_q, rdata_nxt;
    logic [CW-1:0] cnt;
    logic          capture, clr_cnt, illegal, timeout;
    logic [4:0]    k;

    assign k       = bus.iui_hpcp_idx[4:0];
    assign timeout = (cnt == CNT_MAX);

    always_comb begin
        illegal = 1'b0;
        if (bus.regs_smode || bus.regs_umode) begin
            if (bus.iui_hpcp_idx[9:8] == 2'b11)
                illegal = 1'b1;
            else if (bus.regs_smode)
                illegal = !bus.mcnten_value[k] || (bus.iui_hpcp_wen && !bus.mcntwen_value[k]);
            else
                illegal = !bus.mcnten_value[k] || !bus.scnten_value[k] || bus.iui_hpcp_wen;
        end
    end

    always_ff @(posedge regs_clk or negedge cpurst_b) begin
        if (!cpurst_b) state <= S_IDLE;
        else           state <= nxt;
    end

    always_comb begin
        nxt       = state;
        req_nxt   = req_q;
        expt_nxt  = expt_q;
        rdata_nxt = rdata_q;
        capture   = 1'b0;
        clr_cnt   = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.iui_hpcp_req_vld && !bus.iui_flush) begin
                    capture = 1'b1;
                    if (illegal) begin
                        nxt       = S_RESP;
                        expt_nxt  = 1'b1;
                        rdata_nxt = '0;
                    end else begin
                        nxt     = S_ISSUE;
                        req_nxt = 1'b1;
                        clr_cnt = 1'b1;
                    end
                end
            end
            S_ISSUE, S_WAIT: begin
                // ack beats both flush and timeout: HPCP has already done the access
                if (bus.hpcp_cp0_ack) begin
                    req_nxt = 1'b0;
                    if (bus.iui_flush) begin
                        nxt = S_IDLE;
                    end else begin
                        nxt       = S_RESP;
                        expt_nxt  = 1'b0;
                        rdata_nxt = bus.hpcp_cp0_data;
                    end
                end else if (bus.iui_flush) begin
                    nxt = S_DRAIN;
                end else if (timeout) begin
                    req_nxt   = 1'b0;
                    nxt       = S_RESP;
                    expt_nxt  = 1'b1;
                    rdata_nxt = '0;
                end else if (state == S_ISSUE) begin
                    nxt = S_WAIT;
                end
            end
            S_RESP: nxt = S_IDLE;
            S_DRAIN: begin
                if (bus.hpcp_cp0_ack || timeout) begin
                    req_nxt = 1'b0;
                    nxt     = S_IDLE;
                end
            end
            default: begin
                nxt     = S_IDLE;
                req_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge regs_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            req_q   <= 1'b0;
            wen_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            expt_q  <= 1'b0;
            rdata_q <= '0;
            cnt     <= '0;
        end else begin
            req_q   <= req_nxt;
            expt_q  <= expt_nxt;
            rdata_q <= rdata_nxt;
            if (capture) begin
                wen_q   <= bus.iui_hpcp_wen;
                idx_q   <= bus.iui_hpcp_idx;
                wdata_q <= bus.iui_hpcp_wdata;
            end
            if (clr_cnt)
                cnt <= '0;
            else if ((state == S_ISSUE || state == S_WAIT || state == S_DRAIN) && !timeout)
                cnt <= cnt + 1'b1;
        end
    end

    // Response fields are only meaningful alongside done; keep them quiet otherwise.
    assign bus.cp0_hpcp_req   = req_q;
    assign bus.cp0_hpcp_wen   = wen_q;
    assign bus.cp0_hpcp_idx   = idx_q;
    assign bus.cp0_hpcp_wdata = wdata_q;
    assign bus.hpcp_iui_done  = (state == S_RESP) && !bus.iui_flush;
    assign bus.hpcp_iui_expt  = bus.hpcp_iui_done && expt_q;
    assign bus.hpcp_iui_rdata = bus.hpcp_iui_done ? rdata_q : 64'd0;
    assign bus.hpcp_iui_busy  = (state != S_IDLE);
endmodule

// File: tb/tb_aq_cp0_hpcp_acc_ctrl.sv
// Randomized + directed bench for aq_cp0_hpcp_acc_ctrl with a queue-based response scoreboard.
module tb_aq_cp0_hpcp_acc_ctrl;
    localparam int TIMEOUT = 16;

    logic regs_clk = 1'b0;
    logic cpurst_b = 1'b0;
    aq_cp0_hpcp_acc_ctrl_if bus();

    aq_cp0_hpcp_acc_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .regs_clk (regs_clk),
        .cpurst_b (cpurst_b),
        .bus      (bus)
    );

    always #5 regs_clk = ~regs_clk;

    typedef struct {
        logic        expt;
        logic [63:0] rdata;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int cyc = 0;
    int total = 0;
    int passes = 0;
    int done_cnt = 0;
    int pushed = 0;

    always @(posedge regs_clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act === expv) passes++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    endtask

    function automatic bit ref_legal(input int mode, input logic [11:0] idx, input bit wen,
                                     input logic [31:0] mcn, input logic [31:0] scn,
                                     input logic [31:0] mcw);
        int b;
        b = int'(idx[4:0]);
        if (mode == 0) return 1'b1;
        if (idx[9:8] == 2'b11) return 1'b0;
        if (mode == 1) return mcn[b] && (!wen || mcw[b]);
        return mcn[b] && scn[b] && !wen;
    endfunction

    // Monitor: every done pulse must match the oldest expected response
    always @(negedge regs_clk) begin
        if (cpurst_b && bus.hpcp_iui_done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("expt", 64'(bus.hpcp_iui_expt), 64'(e.expt));
                chk("rdata", bus.hpcp_iui_rdata, e.rdata);
                chk("done_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic tick();
        @(posedge regs_clk); #1;
    endtask

    // Drives a one-cycle request; returns one cycle later with t0 = request cycle.
    task automatic start_req(input int mode, input logic [11:0] idx, input logic wen,
                             input logic [63:0] wd, input logic [31:0] mcn, input logic [31:0] scn,
                             input logic [31:0] mcw, output int t0);
        tick();
        bus.regs_smode       = (mode == 1);
        bus.regs_umode       = (mode == 2);
        bus.mcnten_value     = mcn;
        bus.scnten_value     = scn;
        bus.mcntwen_value    = mcw;
        bus.iui_hpcp_idx     = idx;
        bus.iui_hpcp_wen     = wen;
        bus.iui_hpcp_wdata   = wd;
        bus.iui_hpcp_req_vld = 1'b1;
        t0 = cyc;
        tick();
        bus.iui_hpcp_req_vld = 1'b0;
    endtask

    // k = number of req-high cycles before HPCP acks (k >= TIMEOUT: never acks)
    task automatic do_txn(input int mode, input logic [11:0] idx, input logic wen,
                          input logic [63:0] wd, input logic [31:0] mcn, input logic [31:0] scn,
                          input logic [31:0] mcw, input int k, input logic [63:0] hd);
        exp_t e;
        int t0;
        bit lg;
        lg = ref_legal(mode, idx, wen, mcn, scn, mcw);
        if (!lg)              e = '{1'b1, 64'd0, 0};
        else if (k < TIMEOUT) e = '{1'b0, hd, 0};
        else                  e = '{1'b1, 64'd0, 0};
        // push before the request so the monitor always finds it
        e.cyc = (!lg) ? cyc + 2 : (k < TIMEOUT) ? cyc + 3 + k : cyc + TIMEOUT + 2;
        exp_q.push_back(e);
        pushed++;
        start_req(mode, idx, wen, wd, mcn, scn, mcw, t0);
        if (!lg) begin
            chk("illegal_no_req", 64'(bus.cp0_hpcp_req), 64'd0);
            tick();
            chk("illegal_no_req2", 64'(bus.cp0_hpcp_req), 64'd0);
        end else begin
            for (int i = 0; i < TIMEOUT; i++) begin
                chk("req_high", 64'(bus.cp0_hpcp_req), 64'd1);
                if (i == 0) begin
                    chk("req_idx", 64'(bus.cp0_hpcp_idx), 64'(idx));
                    chk("req_wen", 64'(bus.cp0_hpcp_wen), 64'(wen));
                    chk("req_wdata", bus.cp0_hpcp_wdata, wd);
                end
                if (i == k) begin
                    bus.hpcp_cp0_ack  = 1'b1;
                    bus.hpcp_cp0_data = hd;
                    tick();
                    bus.hpcp_cp0_ack  = 1'b0;
                    bus.hpcp_cp0_data = {$urandom, $urandom};
                    break;
                end
                tick();
            end
            chk("req_dropped", 64'(bus.cp0_hpcp_req), 64'd0);
        end
        tick();
        chk("idle_after", 64'(bus.hpcp_iui_busy), 64'd0);
    endtask

    initial begin
        int t0;
        logic [63:0] hd;
        bus.iui_hpcp_req_vld = 0; bus.iui_hpcp_wen = 0; bus.iui_hpcp_idx = 0;
        bus.iui_hpcp_wdata = 0; bus.iui_flush = 0; bus.regs_smode = 0; bus.regs_umode = 0;
        bus.mcnten_value = 0; bus.scnten_value = 0; bus.mcntwen_value = 0;
        bus.hpcp_cp0_ack = 0; bus.hpcp_cp0_data = 0;
        repeat (3) @(posedge regs_clk);
        #1;
        chk("rst_req", 64'(bus.cp0_hpcp_req), 64'd0);
        chk("rst_busy", 64'(bus.hpcp_iui_busy), 64'd0);
        chk("rst_done", 64'(bus.hpcp_iui_done), 64'd0);
        chk("rst_idx", 64'(bus.cp0_hpcp_idx), 64'd0);
        chk("rst_wdata", bus.cp0_hpcp_wdata, 64'd0);
        chk("rst_wen", 64'(bus.cp0_hpcp_wen), 64'd0);
        cpurst_b = 1'b1;

        // Directed privilege and latency cases
        do_txn(0, 12'hC00, 0, 64'h0, 32'h0, 32'h0, 32'h0, 2, 64'h1234);
        do_txn(1, 12'hC02, 0, 64'h0, 32'h5, 32'h0, 32'h0, 0, 64'hABCD_0000_5555);
        do_txn(1, 12'hC02, 0, 64'h0, 32'h3, 32'h0, 32'h0, 0, 64'h1);
        do_txn(1, 12'hC03, 1, 64'h77, 32'h8, 32'h0, 32'h0, 0, 64'h2);
        do_txn(2, 12'hC01, 1, 64'h99, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 64'h3);
        do_txn(2, 12'hC01, 0, 64'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1, 64'h4444);
        do_txn(1, 12'hB00, 0, 64'h0, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 0, 64'h5);
        do_txn(0, 12'h320, 1, 64'hDEAD_BEEF, 32'h0, 32'h0, 32'h0, 0, 64'h6);
        do_txn(0, 12'hC04, 0, 64'h0, 32'h0, 32'h0, 32'h0, TIMEOUT - 1, 64'hFEED);

        // Timeout with a late ack that must be ignored
        do_txn(0, 12'hC05, 0, 64'h0, 32'h0, 32'h0, 32'h0, TIMEOUT, 64'h0);
        bus.hpcp_cp0_ack = 1'b1; bus.hpcp_cp0_data = 64'hBAD0_BAD0;
        tick();
        bus.hpcp_cp0_ack = 1'b0;
        tick();
        chk("late_ack_idle", 64'(bus.hpcp_iui_busy), 64'd0);

        // Flush in WAIT, ack arrives 4 cycles later: busy until ack, no done
        start_req(0, 12'hC06, 0, 64'h0, 32'h0, 32'h0, 32'h0, t0);
        tick();
        bus.iui_flush = 1'b1;
        tick();
        bus.iui_flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("drain_busy", 64'(bus.hpcp_iui_busy), 64'd1);
            chk("drain_req", 64'(bus.cp0_hpcp_req), 64'd1);
            tick();
        end
        bus.hpcp_cp0_ack = 1'b1;
        tick();
        bus.hpcp_cp0_ack = 1'b0;
        chk("drain_done_busy", 64'(bus.hpcp_iui_busy), 64'd0);
        chk("drain_done_req", 64'(bus.cp0_hpcp_req), 64'd0);
        do_txn(0, 12'hC07, 0, 64'h0, 32'h0, 32'h0, 32'h0, 0, 64'h7777);

        // Flush and ack together
        start_req(0, 12'hC08, 0, 64'h0, 32'h0, 32'h0, 32'h0, t0);
        tick();
        bus.iui_flush = 1'b1; bus.hpcp_cp0_ack = 1'b1;
        tick();
        bus.iui_flush = 1'b0; bus.hpcp_cp0_ack = 1'b0;
        chk("flush_ack_idle", 64'(bus.hpcp_iui_busy), 64'd0);

        // Flush during RESP suppresses done (illegal request lands in RESP next cycle)
        start_req(2, 12'hC00, 1, 64'h0, 32'h0, 32'h0, 32'h0, t0);
        bus.iui_flush = 1'b1;
        tick();
        bus.iui_flush = 1'b0;
        chk("flush_resp_idle", 64'(bus.hpcp_iui_busy), 64'd0);

        // Request coinciding with flush is dropped
        tick();
        bus.iui_hpcp_req_vld = 1'b1; bus.iui_flush = 1'b1; bus.regs_smode = 0; bus.regs_umode = 0;
        tick();
        bus.iui_hpcp_req_vld = 1'b0; bus.iui_flush = 1'b0;
        chk("req_flush_drop", 64'(bus.hpcp_iui_busy), 64'd0);
        chk("req_flush_noreq", 64'(bus.cp0_hpcp_req), 64'd0);

        // Async reset during WAIT
        start_req(0, 12'hC09, 0, 64'h0, 32'h0, 32'h0, 32'h0, t0);
        tick();
        #2 cpurst_b = 1'b0;
        #1;
        chk("arst_req", 64'(bus.cp0_hpcp_req), 64'd0);
        chk("arst_busy", 64'(bus.hpcp_iui_busy), 64'd0);
        chk("arst_done", 64'(bus.hpcp_iui_done), 64'd0);
        tick();
        cpurst_b = 1'b1;
        tick();
        chk("arst_idle", 64'(bus.hpcp_iui_busy), 64'd0);

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            int mode, k;
            logic [11:0] idx;
            mode = $urandom_range(0, 2);
            idx  = ($urandom_range(0, 5) == 0) ? (12'h300 | 12'($urandom_range(0, 31)))
                                               : (12'hC00 | 12'($urandom_range(0, 31)));
            k    = ($urandom_range(0, 9) == 0) ? TIMEOUT : $urandom_range(0, 5);
            hd   = {$urandom, $urandom};
            do_txn(mode, idx, 1'($urandom), {$urandom, $urandom}, $urandom | $urandom,
                   $urandom | $urandom, $urandom, k, hd);
        end

        repeat (3) tick();
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        chk("done_count", 64'(done_cnt), 64'(pushed));
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
